psx_ddr_multiport_bridge: RTL and testbench

- Successor to the single-client PSX→DDR bridge. Arbitrates NUM_CLIENTS block-memory clients (GPU, MDEC, SPU…) onto one Avalon-MM DDR master port.
- Client command format is unchanged: 32-byte block address, 8B or 32B size, halfword write mask, 256-bit data.
- New over the predecessor: multiple clients, selectable round-robin or fixed-priority arbitration, parametrised memory width and base offset, and a per-client completion pulse for writes.

---
 rtl/psx_ddr_pkg.sv | 29 ++
 rtl/psx_rr_arbiter.sv | 50 +++++
 rtl/psx_ddr_multiport_bridge.sv | 203 ++++++++++++++++++++
 tb/tb_psx_ddr_multiport_bridge.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psx_ddr_pkg.sv
// Shared definitions for the multi-client PSX -> DDR bridge.
package psx_ddr_pkg;

  // Client command size encodings; 2 and 3 are reserved and behave as 8B.
  localparam logic [1:0] SZ_8B  = 2'd0;
  localparam logic [1:0] SZ_32B = 2'd1;

  // A 32-byte block is four 64-bit DDR beats / lanes.
  localparam int BURST_32B = 4;
  localparam int LANES     = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_BEAT = 2'd1,
    ST_RD_CMD  = 2'd2,
    ST_RD_WAIT = 2'd3
  } state_t;

  // Expand four halfword enables of one lane into eight byte enables.
  function automatic logic [7:0] hw_mask_to_be(input logic [3:0] hw);
    logic [7:0] be;
    be = '0;
    for (int j = 0; j < 4; j++) begin
      be[2*j +: 2] = {2{hw[j]}};
    end
    return be;
  endfunction

endpackage

// File: rtl/psx_rr_arbiter.sv
// Client arbiter: round-robin (MODE 0) or fixed priority, lowest index wins (MODE 1).
// Grant is combinational from the request vector; the pointer moves on update.
module psx_rr_arbiter #(
  parameter int NUM_CLIENTS = 3,
  parameter int MODE        = 0,
  parameter int IDX_W       = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic                   update,
  output logic [NUM_CLIENTS-1:0] grant,
  output logic [IDX_W-1:0]       grant_idx
);

  logic [IDX_W-1:0] ptr;
  logic             found;
  int               cand;

  // Search starts one past the last grant so every requester is served once per N grants.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      if (MODE == 1) begin
        cand = k;
      end else begin
        cand = int'(ptr) + 1 + k;
        if (cand >= NUM_CLIENTS) cand = cand - NUM_CLIENTS;
      end
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  // Remember the last winner; reset points at the last client so client 0 goes first.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= IDX_W'(NUM_CLIENTS - 1);
    end else if (update && (|grant)) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/psx_ddr_multiport_bridge.sv
// Arbitrates several 32-byte block clients onto one Avalon-MM DDR master.
// Handshake: a client holds i_command with stable fields until o_accept pulses;
// the Avalon side advances a write beat or the read command only while
// i_busyMem (waitrequest) is low, and read beats arrive on i_dataValidMem.
module psx_ddr_multiport_bridge
  import psx_ddr_pkg::*;
#(
  parameter int                   NUM_CLIENTS = 3,
  parameter int                   ARB_MODE    = 0,
  parameter int                   BLK_ADR_W   = 15,
  parameter int                   MEM_ADR_W   = 17,
  parameter int                   MEM_DATA_W  = 64,
  parameter logic [MEM_ADR_W-1:0] BASE_OFFSET = '0
) (
  input  logic                             clk,
  input  logic                             i_rst,
  input  logic [NUM_CLIENTS-1:0]           i_command,
  input  logic [NUM_CLIENTS-1:0]           i_writeElseRead,
  input  logic [2*NUM_CLIENTS-1:0]         i_commandSize,
  input  logic [NUM_CLIENTS*BLK_ADR_W-1:0] i_targetAddr,
  input  logic [3*NUM_CLIENTS-1:0]         i_subAddr,
  input  logic [16*NUM_CLIENTS-1:0]        i_writeMask,
  input  logic [256*NUM_CLIENTS-1:0]       i_dataClient,
  output logic [NUM_CLIENTS-1:0]           o_accept,
  output logic [NUM_CLIENTS-1:0]           o_busyClient,
  output logic [NUM_CLIENTS-1:0]           o_writeDone,
  output logic [NUM_CLIENTS-1:0]           o_dataValidClient,
  output logic [255:0]                     o_dataClient,
  output logic [MEM_ADR_W-1:0]             o_targetAddr,
  output logic [2:0]                       o_burstLength,
  input  logic                             i_busyMem,
  output logic                             o_writeEnableMem,
  output logic                             o_readEnableMem,
  output logic [63:0]                      o_dataMem,
  output logic [7:0]                       o_byteEnableMem,
  input  logic                             i_dataValidMem,
  input  logic [63:0]                      i_dataMem,
  output logic [1:0]                       debug_state
);

  localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  if (MEM_DATA_W != 64) begin : g_bad_data_width
    $error("psx_ddr_multiport_bridge: only MEM_DATA_W = 64 is supported");
  end
  if (MEM_ADR_W < BLK_ADR_W + 2) begin : g_bad_adr_width
    $error("psx_ddr_multiport_bridge: MEM_ADR_W must be at least BLK_ADR_W + 2");
  end
  if (NUM_CLIENTS < 2 || NUM_CLIENTS > 8) begin : g_bad_clients
    $error("psx_ddr_multiport_bridge: NUM_CLIENTS must be 2..8");
  end

  state_t                   state;
  logic [NUM_CLIENTS-1:0]   grant;
  logic [IDX_W-1:0]         grant_idx;
  logic [NUM_CLIENTS-1:0]   owner;
  logic                     is_32b;
  logic [1:0]               sub_lane;
  logic [1:0]               beat;
  logic [1:0]               lane;
  logic                     last_beat;
  logic [15:0]              mask;
  logic [255:0]             wdata;
  logic [255:0]             rdata;
  logic [NUM_CLIENTS-1:0]   write_done;
  logic [NUM_CLIENTS-1:0]   data_valid;
  logic                     wr_en;
  logic                     rd_en;
  logic [MEM_ADR_W-1:0]     addr;
  logic [2:0]               burst;

  int                       gi;
  logic                     sel_wr;
  logic                     sel_32b;
  logic [1:0]               sel_sub_lane;
  logic [BLK_ADR_W-1:0]     sel_blk;
  logic [15:0]              sel_mask;
  logic [255:0]             sel_data;
  logic [1:0]               sel_lane;
  logic [MEM_ADR_W-1:0]     sel_addr;
  logic                     unused_sub_bits;

  psx_rr_arbiter #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .MODE        (ARB_MODE),
    .IDX_W       (IDX_W)
  ) u_arbiter (
    .clk       (clk),
    .rst       (i_rst),
    .req       (i_command),
    .update    (state == ST_IDLE),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Pick out the winning client's fields and form its DDR word address.
  // A 32B block starts at lane 0; an 8B access addresses its own lane directly.
  always_comb begin
    gi           = int'(grant_idx);
    sel_wr       = i_writeElseRead[gi];
    sel_32b      = (i_commandSize[2*gi +: 2] == SZ_32B);
    sel_sub_lane = i_subAddr[3*gi+1 +: 2];
    sel_blk      = i_targetAddr[BLK_ADR_W*gi +: BLK_ADR_W];
    sel_mask     = i_writeMask[16*gi +: 16];
    sel_data     = i_dataClient[256*gi +: 256];
    sel_lane     = sel_32b ? 2'b00 : sel_sub_lane;
    sel_addr     = BASE_OFFSET + MEM_ADR_W'({sel_blk, sel_lane});
  end

  // Sub-address bit 0 is below 8B granularity and never affects the access.
  assign unused_sub_bits = ^i_subAddr;

  assign lane      = is_32b ? beat : sub_lane;
  assign last_beat = !is_32b || (beat == 2'(LANES - 1));

  assign o_accept          = (state == ST_IDLE) ? grant : '0;
  assign o_busyClient      = {NUM_CLIENTS{state != ST_IDLE}} | (i_command & ~o_accept);
  assign o_writeDone       = write_done;
  assign o_dataValidClient = data_valid;
  assign o_dataClient      = rdata;
  assign o_targetAddr      = addr;
  assign o_burstLength     = burst;
  assign o_writeEnableMem  = wr_en;
  assign o_readEnableMem   = rd_en;
  assign o_dataMem         = wdata[64*lane +: 64];
  assign o_byteEnableMem   = hw_mask_to_be(mask[4*lane +: 4]);
  assign debug_state       = state;

  // Command FSM: capture the granted command, run the write burst or read, pulse completion.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      owner      <= '0;
      is_32b     <= 1'b0;
      sub_lane   <= 2'b00;
      beat       <= 2'b00;
      mask       <= '0;
      wdata      <= '0;
      rdata      <= '0;
      write_done <= '0;
      data_valid <= '0;
      wr_en      <= 1'b0;
      rd_en      <= 1'b0;
      addr       <= '0;
      burst      <= '0;
    end else begin
      write_done <= '0;
      data_valid <= '0;
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            owner    <= grant;
            is_32b   <= sel_32b;
            sub_lane <= sel_sub_lane;
            beat     <= 2'b00;
            mask     <= sel_mask;
            wdata    <= sel_data;
            addr     <= sel_addr;
            burst    <= sel_32b ? 3'(BURST_32B) : 3'd1;
            if (sel_wr) begin
              state <= ST_WR_BEAT;
              wr_en <= 1'b1;
            end else begin
              state <= ST_RD_CMD;
              rd_en <= 1'b1;
              rdata <= '0;
            end
          end
        end
        ST_WR_BEAT: begin
          if (!i_busyMem) begin
            if (last_beat) begin
              state      <= ST_IDLE;
              wr_en      <= 1'b0;
              write_done <= owner;
            end else begin
              beat <= beat + 2'd1;
            end
          end
        end
        ST_RD_CMD: begin
          if (!i_busyMem) begin
            state <= ST_RD_WAIT;
            rd_en <= 1'b0;
          end
        end
        ST_RD_WAIT: begin
          if (i_dataValidMem) begin
            rdata[64*lane +: 64] <= i_dataMem;
            if (last_beat) begin
              state      <= ST_IDLE;
              data_valid <= owner;
            end else begin
              beat <= beat + 2'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psx_ddr_multiport_bridge.sv
// Directed bench for the multi-client DDR bridge. Two instances share all inputs:
// dut_a uses round-robin with no offset, dut_b fixed priority with offset 0x1FFFC.
module tb_psx_ddr_multiport_bridge;
  import psx_ddr_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic [2:0]   cmd, wer;
  logic [5:0]   size;
  logic [44:0]  taddr;
  logic [8:0]   sub;
  logic [47:0]  mask;
  logic [767:0] wdata;
  logic         busy_mem, dv_mem;
  logic [63:0]  rdata_mem;

  // ---------------- DUT outputs ----------------
  logic [2:0]   a_accept, a_busy, a_wdone, a_dv, b_accept, b_busy, b_wdone, b_dv;
  logic [255:0] a_data, b_data;
  logic [16:0]  a_addr, b_addr;
  logic [2:0]   a_burst, b_burst;
  logic         a_wr, a_rd, b_wr, b_rd;
  logic [63:0]  a_wdata, b_wdata;
  logic [7:0]   a_be, b_be;
  logic [1:0]   a_state, b_state;

  psx_ddr_multiport_bridge #(.NUM_CLIENTS(3), .ARB_MODE(0), .BASE_OFFSET(17'h00000)) dut_a (
    .clk(clk), .i_rst(rst), .i_command(cmd), .i_writeElseRead(wer), .i_commandSize(size),
    .i_targetAddr(taddr), .i_subAddr(sub), .i_writeMask(mask), .i_dataClient(wdata),
    .o_accept(a_accept), .o_busyClient(a_busy), .o_writeDone(a_wdone),
    .o_dataValidClient(a_dv), .o_dataClient(a_data), .o_targetAddr(a_addr),
    .o_burstLength(a_burst), .i_busyMem(busy_mem), .o_writeEnableMem(a_wr),
    .o_readEnableMem(a_rd), .o_dataMem(a_wdata), .o_byteEnableMem(a_be),
    .i_dataValidMem(dv_mem), .i_dataMem(rdata_mem), .debug_state(a_state)
  );

  psx_ddr_multiport_bridge #(.NUM_CLIENTS(3), .ARB_MODE(1), .BASE_OFFSET(17'h1FFFC)) dut_b (
    .clk(clk), .i_rst(rst), .i_command(cmd), .i_writeElseRead(wer), .i_commandSize(size),
    .i_targetAddr(taddr), .i_subAddr(sub), .i_writeMask(mask), .i_dataClient(wdata),
    .o_accept(b_accept), .o_busyClient(b_busy), .o_writeDone(b_wdone),
    .o_dataValidClient(b_dv), .o_dataClient(b_data), .o_targetAddr(b_addr),
    .o_burstLength(b_burst), .i_busyMem(busy_mem), .o_writeEnableMem(b_wr),
    .o_readEnableMem(b_rd), .o_dataMem(b_wdata), .o_byteEnableMem(b_be),
    .i_dataValidMem(dv_mem), .i_dataMem(rdata_mem), .debug_state(b_state)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard of expected accepted write beats on dut_a: {addr, byteenable, data}.
  logic [88:0] exp_q[$];
  logic        mon_en = 1'b1;
  int          dv_seen = 0;

  always @(negedge clk) begin
    if (mon_en && !rst && a_wr && !busy_mem) begin
      if (exp_q.size() == 0) check("wr_unexpected_beat", 1, 0);
      else check("wr_beat", {a_addr, a_be, a_wdata}, exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (|a_dv) dv_seen <= dv_seen + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- helpers / drivers ----------------
  function automatic logic [255:0] make_data(input logic [63:0] base);
    logic [255:0] d;
    for (int k = 0; k < 4; k++) d[64*k +: 64] = base + 64'(k);
    return d;
  endfunction

  function automatic int onehot_idx(input logic [2:0] v);
    int r;
    r = -1;
    for (int k = 0; k < 3; k++) if (v[k]) r = k;
    return r;
  endfunction

  task automatic set_client(input int c, input logic wr, input logic [1:0] sz,
                            input logic [14:0] blk, input logic [2:0] sb,
                            input logic [15:0] mk, input logic [255:0] d);
    wer[c]             = wr;
    size[2*c +: 2]     = sz;
    taddr[15*c +: 15]  = blk;
    sub[3*c +: 3]      = sb;
    mask[16*c +: 16]   = mk;
    wdata[256*c +: 256] = d;
  endtask

  // Raise one client's request, wait for its accept, then withdraw it.
  task automatic issue(input int c);
    bit seen;
    seen = 1'b0;
    @(posedge clk); #1;
    cmd[c] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (a_accept[c]) begin
        seen = 1'b1;
        break;
      end
    end
    check("accept_seen", seen, 1);
    @(posedge clk); #1;
    cmd[c] = 1'b0;
  endtask

  task automatic wait_pulse(input string tag, input int c, input logic is_read);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (is_read ? a_dv[c] : a_wdone[c]) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, seen, 1);
  endtask

  task automatic mem_beat(input logic [63:0] d, input int gap);
    repeat (gap) begin
      @(posedge clk); #1;
    end
    dv_mem    = 1'b1;
    rdata_mem = d;
    @(posedge clk); #1;
    dv_mem    = 1'b0;
    rdata_mem = '0;
  endtask

  // ---------------- stimulus ----------------
  int          a_order[$];
  int          b_order[$];
  int          dv_before;
  logic [255:0] d;

  initial begin
    rst = 1'b1; cmd = '0; wer = '0; size = '0; taddr = '0; sub = '0; mask = '0;
    wdata = '0; busy_mem = 1'b0; dv_mem = 1'b0; rdata_mem = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_state", a_state, ST_IDLE);
    check("rst_wr", a_wr, 0);
    check("rst_rd", a_rd, 0);
    check("rst_data", a_data, 0);
    check("rst_pulses", {a_accept, a_wdone, a_dv}, 0);
    check("rst_busy", a_busy, 0);

    // All three clients requesting continuously: RR vs fixed priority.
    mon_en = 1'b0;
    for (int c = 0; c < 3; c++) set_client(c, 1'b1, SZ_8B, 15'(c), 3'd0, 16'hFFFF, '0);
    @(posedge clk); #1;
    cmd = 3'b111;
    for (int k = 0; k < 40 && a_order.size() < 6; k++) begin
      @(negedge clk);
      if (|a_accept) begin
        if (a_order.size() == 0) begin
          check("t3_a_busy_first", a_busy, 3'b110);
          check("t3_b_busy_first", b_busy, 3'b110);
        end
        check("t3_a_onehot", $countones(a_accept), 1);
        a_order.push_back(onehot_idx(a_accept));
      end
      if (|b_accept) b_order.push_back(onehot_idx(b_accept));
    end
    @(posedge clk); #1;
    cmd = 3'b000;
    repeat (3) begin
      @(posedge clk); #1;
    end
    mon_en = 1'b1;
    check("t3_a_count", a_order.size(), 6);
    check("t3_b_count", b_order.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check("t3_rr_order", (i < a_order.size()) ? a_order[i] : 99, i % 3);
      check("t3_fixed_order", (i < b_order.size()) ? b_order[i] : 99, 0);
    end

    // Client 0, 32B write at block 0x10 with waitrequest on beat 1 for two cycles.
    d = make_data(64'hA000_0000_0000_0010);
    set_client(0, 1'b1, SZ_32B, 15'h0010, 3'd0, 16'hFFFF, d);
    for (int k = 0; k < 4; k++) exp_q.push_back({17'h00040, 8'hFF, d[64*k +: 64]});
    issue(0);
    @(posedge clk); #1;
    busy_mem = 1'b1;
    @(negedge clk);
    check("t1_hold_addr", a_addr, 17'h00040);
    check("t1_burst", a_burst, 3'd4);
    check("t1_hold_data", a_wdata, d[127:64]);
    check("t1_busy_all", a_busy, 3'b111);
    check("t1_b_addr_wrap", b_addr, 17'h0003C);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_hold_wr", {a_wr, a_addr}, {1'b1, 17'h00040});
    @(posedge clk); #1;
    busy_mem = 1'b0;
    wait_pulse("t1_write_done", 0, 1'b0);
    check("t1_done_vec", a_wdone, 3'b001);
    check("t1_state_idle", a_state, ST_IDLE);
    check("t1_queue_drained", exp_q.size(), 0);

    // 8B write, sub 2 -> lane 1, halfwords 2,3 of lane 1 -> byteenable 0xF0.
    d = make_data(64'hB000_0000_0000_0020);
    set_client(2, 1'b1, SZ_8B, 15'h0123, 3'd2, 16'h00C0, d);
    exp_q.push_back({17'h0048D, 8'hF0, d[127:64]});
    issue(2);
    @(negedge clk);
    check("t4_burst", a_burst, 3'd1);
    wait_pulse("t4_write_done", 2, 1'b0);

    // Reserved size 2 acts as 8B; empty lane-0 mask still issues a beat.
    d = make_data(64'hC000_0000_0000_0030);
    set_client(1, 1'b1, 2'd2, 15'h0005, 3'd1, 16'hFFF0, d);
    exp_q.push_back({17'h00014, 8'h00, d[63:0]});
    issue(1);
    wait_pulse("t4z_write_done", 1, 1'b0);
    check("t4_queue_drained", exp_q.size(), 0);

    // Client 1, 8B read, blk 0x7FFF, sub 6 -> address 0x1FFFF, lane 3.
    dv_before = dv_seen;
    set_client(1, 1'b0, SZ_8B, 15'h7FFF, 3'd6, 16'h0000, '0);
    issue(1);
    @(negedge clk);
    check("t2_rd", a_rd, 1);
    check("t2_addr", a_addr, 17'h1FFFF);
    check("t2_burst", a_burst, 3'd1);
    check("t2_b_addr", b_addr, 17'h1FFFB);
    mem_beat(64'hDEADBEEF_CAFEF00D, 3);
    wait_pulse("t2_read_valid", 1, 1'b1);
    check("t2_valid_vec", a_dv, 3'b010);
    check("t2_data", a_data, {64'hDEADBEEF_CAFEF00D, 192'h0});
    repeat (3) @(negedge clk);
    check("t2_single_pulse", dv_seen - dv_before, 1);

    // Reset in RD_WAIT after two of four beats; late beats must be ignored.
    d = make_data(64'hE000_0000_0000_0050);
    set_client(0, 1'b0, SZ_32B, 15'h0020, 3'd0, 16'h0000, '0);
    dv_before = dv_seen;
    issue(0);
    @(negedge clk);
    check("t5_addr", a_addr, 17'h00080);
    mem_beat(d[63:0], 1);
    mem_beat(d[127:64], 1);
    @(negedge clk);
    check("t5_partial_data", a_data, {128'h0, d[127:0]});
    check("t5_state_wait", a_state, ST_RD_WAIT);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_state_idle", a_state, ST_IDLE);
    check("t5_data_cleared", a_data, 0);
    check("t5_enables", {a_wr, a_rd}, 2'b00);
    mem_beat(d[191:128], 1);
    mem_beat(d[255:192], 1);
    repeat (2) @(negedge clk);
    check("t5_no_valid", dv_seen - dv_before, 0);
    check("t5_still_idle", {a_state, a_data}, 0);

    // 32B read of blk 1: dut_b wraps 0x1FFFC + 4 to 0; lanes fill in order.
    d = make_data(64'hF000_0000_0000_0060);
    set_client(2, 1'b0, SZ_32B, 15'h0001, 3'd0, 16'h0000, '0);
    dv_before = dv_seen;
    issue(2);
    @(negedge clk);
    check("t6_a_addr", a_addr, 17'h00004);
    check("t6_b_addr_wrap", b_addr, 17'h00000);
    check("t6_burst", a_burst, 3'd4);
    mem_beat(d[63:0], 1);
    mem_beat(d[127:64], 2);
    mem_beat(d[191:128], 1);
    mem_beat(d[255:192], 3);
    wait_pulse("t6_read_valid", 2, 1'b1);
    check("t6_a_data", a_data, d);
    check("t6_b_data", b_data, d);
    repeat (2) @(negedge clk);
    check("t6_single_pulse", dv_seen - dv_before, 1);

    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
